mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-port 16-bit unified memory between the IF-stage instruction fetch
//  and the M-stage data access of the 5-stage CPU.
//  - Fixed priority: data wins, with a burst limit so fetch is not starved.
//  - Bounded-wait timeout aborts a hung access and reports an error.
//  - Drives the stall requests the hazard logic uses to freeze IF and M.
// PARAMETERS
//  ADDR_W      16  address width (word addressed)
//  DATA_W      16  data width
//  TIMEOUT     15  max cycles mem_req may wait for mem_ack; 0 = timeout disabled
//  DATA_BURST  4   max consecutive data grants while if_req is pending (>=1)
// PORTS
//  clk         in   1       rising-edge clock
//  reset       in   1       asynchronous, active-high reset
//  if_req      in   1       fetch request; held high until if_ack
//  if_addr     in   ADDR_W  fetch address (PC)
//  if_rdata    out  DATA_W  instruction returned; valid while if_ack=1
//  if_ack      out  1       one-cycle completion pulse to fetch
//  dm_req      in   1       data request; held high until dm_ack
//  dm_we       in   1       1 = write, 0 = read
//  dm_addr     in   ADDR_W  data address
//  dm_wdata    in   DATA_W  write data
//  dm_rdata    out  DATA_W  read data; valid while dm_ack=1 (0 on a write)
//  dm_ack      out  1       one-cycle completion pulse to M stage
//  mem_req     out  1       memory access strobe; held until mem_ack or timeout
//  mem_we      out  1       memory write enable
//  mem_addr    out  ADDR_W  memory address
//  mem_wdata   out  DATA_W  memory write data
//  mem_rdata   in   DATA_W  memory read data; valid when mem_ack=1
//  mem_ack     in   1       memory done, sampled only while mem_req=1
//  stall_if    out  1       comb: if_req & ~if_ack
//  stall_mem   out  1       comb: dm_req & ~dm_ack
//  bus_err     out  1       one-cycle pulse on timeout abort
//  err_sticky  out  1       set by any timeout; cleared only by reset
// BEHAVIOUR
//  - Reset values: state=IDLE; burst_cnt=0; wait_cnt=0.
//    Outputs: mem_req/mem_we/if_ack/dm_ack/bus_err/err_sticky=0; all data/addr outputs=0.
//  - Reset mid-access abandons the access immediately: mem_req drops, no ack is issued.
//  - FSM states: IDLE, FETCH, DATA, RESP. All outputs are registered except stall_if/stall_mem.
//  - IDLE:
//    - dm_req & (burst_cnt<DATA_BURST | ~if_req) -> DATA; dm_addr/dm_we/dm_wdata latched to mem_*.
//    - else if_req -> FETCH; if_addr latched to mem_addr, mem_we=0.
//    - else stay IDLE.
//    - mem_req=1 from the cycle after the grant edge.
//  - FETCH/DATA: mem_* stay stable while waiting; wait_cnt increments each cycle mem_ack=0.
//  - mem_ack=1 -> RESP:
//    - Ack pulse to the owner; rdata <= mem_rdata (dm_rdata <= 0 on a write); mem_req <= 0.
//  - wait_cnt==TIMEOUT and mem_ack=0 -> RESP:
//    - Owner acked with rdata=all-ones; bus_err pulse; err_sticky <= 1; mem_req <= 0.
//  - Same-cycle mem_ack and timeout: mem_ack wins, no error.
//  - RESP: one bubble cycle, then -> IDLE. Requests are not sampled here, so a still-high
//    req is not re-granted.
//  - Timing: zero-wait memory = grant edge, mem_req cycle 1, ack cycle 2, IDLE cycle 3.
//    Throughput = 1 access per 3 cycles + wait states.
//  - burst_cnt:
//    - +1 (saturating at DATA_BURST) on each DATA grant made while if_req=1.
//    - Cleared on any FETCH grant, and on any grant made while if_req=0.
//  - Requester dropping req mid-access is ignored: the access completes and the ack is still
//    pulsed.
//  - mem_ack while mem_req=0 is ignored.
// TESTING
//  1. Zero-wait fetch: reset then release; if_req=1, if_addr=0x0004; mem acks same cycle with
//     0x1234 -> mem_req high 1 cycle, if_ack 1 cycle later with if_rdata=0x1234,
//     stall_if high until then.
//  2. Simultaneous req: if_req=dm_req=1, dm_we=1, dm_addr=0x0010, dm_wdata=0xBEEF ->
//     DATA granted first (mem_we=1, mem_addr=0x0010), dm_ack, dm_rdata=0;
//     FETCH granted next IDLE.
//  3. Starvation guard: dm_req and if_req held high, DATA_BURST=4 -> exactly 4 dm_acks,
//     then 1 if_ack, then DATA resumes.
//  4. Timeout: memory never acks, TIMEOUT=15 -> mem_req drops after 16 waiting cycles;
//     if_ack with if_rdata=0xFFFF; bus_err 1-cycle pulse; err_sticky stays 1 until reset.
//  5. 3-wait-state read: ack on the 4th mem_req cycle with 0x00A5 -> dm_ack, dm_rdata=0x00A5,
//     no bus_err; ack and timeout on the same cycle -> data returned, no error.
//  6. Reset asserted while mem_req=1 -> mem_req, acks and err_sticky go 0 asynchronously;
//     after release, a new if_req is granted normally.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and data access; data has priority, with a burst limit.
// Latency: grant edge, then mem_req, ack pulse and a bubble -> 3 cycles per access plus wait states; stalls are combinational.
// Backpressure: requesters hold req until their ack; a hung memory is aborted after TIMEOUT wait cycles with an error.
module mem_port_arbiter #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 16,
    parameter int TIMEOUT    = 15,
    parameter int DATA_BURST = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ack,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_ack,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              stall_if,
    output logic              stall_mem,
    output logic              bus_err,
    output logic              err_sticky
);

    localparam int WC_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int BC_W = $clog2(DATA_BURST + 1);
    localparam logic [WC_W-1:0] TMO_VAL   = WC_W'(TIMEOUT);
    localparam logic [BC_W-1:0] BURST_MAX = BC_W'(DATA_BURST);

    typedef enum logic [1:0] {IDLE, FETCH, DATA, RESP} state_t;

    state_t          state;
    logic [WC_W-1:0] wait_cnt;
    logic [BC_W-1:0] burst_cnt;
    logic            burst_ok;
    logic            timeout_hit;

    assign burst_ok    = (burst_cnt < BURST_MAX);
    assign timeout_hit = (TIMEOUT != 0) && (wait_cnt == TMO_VAL);

    assign stall_if  = if_req & ~if_ack;
    assign stall_mem = dm_req & ~dm_ack;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            wait_cnt   <= '0;
            burst_cnt  <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            if_rdata   <= '0;
            dm_rdata   <= '0;
            if_ack     <= 1'b0;
            dm_ack     <= 1'b0;
            bus_err    <= 1'b0;
            err_sticky <= 1'b0;
        end else begin
            if_ack  <= 1'b0;
            dm_ack  <= 1'b0;
            bus_err <= 1'b0;
            case (state)
                IDLE: begin
                    wait_cnt <= '0;
                    // A data grant with fetch pending implies burst_ok, so +1 never exceeds DATA_BURST.
                    if (dm_req && (burst_ok || !if_req)) begin
                        state     <= DATA;
                        mem_req   <= 1'b1;
                        mem_we    <= dm_we;
                        mem_addr  <= dm_addr;
                        mem_wdata <= dm_wdata;
                        burst_cnt <= if_req ? burst_cnt + 1'b1 : '0;
                    end else if (if_req) begin
                        state     <= FETCH;
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b0;
                        mem_addr  <= if_addr;
                        burst_cnt <= '0;
                    end
                end
                FETCH, DATA: begin
                    if (mem_ack) begin
                        state   <= RESP;
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        if (state == DATA) begin
                            dm_ack   <= 1'b1;
                            dm_rdata <= mem_we ? '0 : mem_rdata;
                        end else begin
                            if_ack   <= 1'b1;
                            if_rdata <= mem_rdata;
                        end
                    end else if (timeout_hit) begin
                        state      <= RESP;
                        mem_req    <= 1'b0;
                        mem_we     <= 1'b0;
                        bus_err    <= 1'b1;
                        err_sticky <= 1'b1;
                        if (state == DATA) begin
                            dm_ack   <= 1'b1;
                            dm_rdata <= '1;
                        end else begin
                            if_ack   <= 1'b1;
                            if_rdata <= '1;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                RESP: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: fetch, priority, burst guard, timeout, wait states, async reset.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        if_req = 1'b0;
    logic [15:0] if_addr = '0;
    logic [15:0] if_rdata;
    logic        if_ack;
    logic        dm_req = 1'b0;
    logic        dm_we = 1'b0;
    logic [15:0] dm_addr = '0;
    logic [15:0] dm_wdata = '0;
    logic [15:0] dm_rdata;
    logic        dm_ack;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_ack;
    logic        stall_if;
    logic        stall_mem;
    logic        bus_err;
    logic        err_sticky;

    // Memory responder: acks on the ack_after-th cycle of mem_req (0 = never).
    int          ack_after = 1;
    int          req_cyc = 0;
    logic [15:0] rd_val = '0;
    logic        stray_ack = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    always @(posedge clk) req_cyc <= mem_req ? req_cyc + 1 : 0;

    assign mem_ack   = stray_ack | (mem_req && ack_after != 0 && (req_cyc + 1) == ack_after);
    assign mem_rdata = rd_val;

    mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .TIMEOUT(15), .DATA_BURST(4)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_ack(dm_ack),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .stall_if(stall_if), .stall_mem(stall_mem), .bus_err(bus_err), .err_sticky(err_sticky)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        int seq[$];
        int exp_seq[6];
        exp_seq = '{1, 1, 1, 1, 0, 1};

        // Reset state
        step(); step();
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_acks", {if_ack, dm_ack}, 0);
        chk("rst_err", {bus_err, err_sticky}, 0);
        chk("rst_rdata", {if_rdata, dm_rdata}, 0);
        reset = 1'b0;

        // 1. Zero-wait fetch
        if_req = 1'b1; if_addr = 16'h0004; ack_after = 1; rd_val = 16'h1234;
        #1;
        chk("t1_stall_pre", stall_if, 1);
        chk("t1_memreq_pre", mem_req, 0);
        step();
        chk("t1_memreq", mem_req, 1);
        chk("t1_addr", mem_addr, 16'h0004);
        chk("t1_we", mem_we, 0);
        chk("t1_ack_early", if_ack, 0);
        step();
        chk("t1_memreq_drop", mem_req, 0);
        chk("t1_ack", if_ack, 1);
        chk("t1_rdata", if_rdata, 16'h1234);
        chk("t1_stall_post", stall_if, 0);
        if_req = 1'b0;
        step();
        chk("t1_ack_pulse", if_ack, 0);

        // 2. Simultaneous requests: data first, fetch next
        if_req = 1'b1; if_addr = 16'h0008;
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 16'h0010; dm_wdata = 16'hBEEF;
        rd_val = 16'h5678;
        step();
        chk("t2_memreq", mem_req, 1);
        chk("t2_we", mem_we, 1);
        chk("t2_addr", mem_addr, 16'h0010);
        chk("t2_wdata", mem_wdata, 16'hBEEF);
        chk("t2_stall_mem", stall_mem, 1);
        step();
        chk("t2_dm_ack", {dm_ack, if_ack}, 2'b10);
        chk("t2_dm_rdata", dm_rdata, 0);
        chk("t2_stalls", {stall_if, stall_mem}, 2'b10);
        dm_req = 1'b0; dm_we = 1'b0;
        step();
        chk("t2_resp_bubble", {mem_req, dm_ack}, 0);
        step();
        chk("t2_fetch_grant", mem_req, 1);
        chk("t2_fetch_addr", mem_addr, 16'h0008);
        chk("t2_fetch_we", mem_we, 0);
        step();
        chk("t2_if_ack", if_ack, 1);
        chk("t2_if_rdata", if_rdata, 16'h5678);
        if_req = 1'b0;
        step();

        // 3. Starvation guard: 4 data grants, then one fetch
        if_req = 1'b1; if_addr = 16'h0040;
        dm_req = 1'b1; dm_addr = 16'h0050;
        n = 0;
        while (seq.size() < 6 && n < 60) begin
            step();
            n++;
            if (dm_ack) seq.push_back(1);
            if (if_ack) seq.push_back(0);
        end
        chk("t3_count", seq.size(), 6);
        chk("t3_cycles", n, 17);
        foreach (seq[i]) chk($sformatf("t3_order%0d", i), seq[i], exp_seq[i]);
        if_req = 1'b0; dm_req = 1'b0;
        step();

        // Stray ack while idle is ignored
        stray_ack = 1'b1;
        step(); step();
        chk("stray_ack", {mem_req, if_ack, dm_ack, bus_err}, 0);
        stray_ack = 1'b0;

        // 4. Timeout on a fetch
        ack_after = 0; if_req = 1'b1; if_addr = 16'h0060;
        step();
        n = 0;
        while (mem_req && n < 40) begin
            n++;
            step();
        end
        chk("t4_wait_cycles", n, 16);
        chk("t4_if_ack", if_ack, 1);
        chk("t4_rdata", if_rdata, 16'hFFFF);
        chk("t4_bus_err", bus_err, 1);
        chk("t4_sticky", err_sticky, 1);
        if_req = 1'b0;
        step();
        chk("t4_bus_err_pulse", bus_err, 0);
        chk("t4_sticky_hold", err_sticky, 1);

        // 5. Three wait states, then ack coinciding with the timeout
        ack_after = 4; rd_val = 16'h00A5;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 16'h0020;
        step();
        n = 0;
        while (!dm_ack && n < 40) begin
            n++;
            step();
        end
        chk("t5_wait", n, 4);
        chk("t5_rdata", dm_rdata, 16'h00A5);
        chk("t5_no_err", bus_err, 0);
        dm_req = 1'b0;
        step();
        ack_after = 16; rd_val = 16'h0F0F; dm_req = 1'b1;
        step();
        n = 0;
        while (!dm_ack && n < 40) begin
            n++;
            step();
        end
        chk("t5_edge_wait", n, 16);
        chk("t5_edge_rdata", dm_rdata, 16'h0F0F);
        chk("t5_edge_no_err", bus_err, 0);
        dm_req = 1'b0;
        step();

        // 6. Asynchronous reset mid-access
        ack_after = 0; if_req = 1'b1; if_addr = 16'h0070;
        step(); step();
        chk("t6_busy", mem_req, 1);
        #2 reset = 1'b1;
        #1;
        chk("t6_async_memreq", mem_req, 0);
        chk("t6_async_sticky", err_sticky, 0);
        chk("t6_async_acks", {if_ack, dm_ack, bus_err}, 0);
        if_req = 1'b0;
        step();
        reset = 1'b0;
        ack_after = 1; rd_val = 16'h4321; if_req = 1'b1; if_addr = 16'h0030;
        step();
        chk("t6_regrant", mem_req, 1);
        chk("t6_regrant_addr", mem_addr, 16'h0030);
        step();
        chk("t6_if_ack", if_ack, 1);
        chk("t6_rdata", if_rdata, 16'h4321);
        chk("t6_no_err", err_sticky, 0);
        if_req = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
